// File: rtl/square_ram_pkg.sv
// Shared types and default sizes for the square RAM and the stages that feed it.
package square_ram_pkg;

  localparam int SQUARE_RAM_DATA_WIDTH = 8;
  localparam int SQUARE_RAM_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } loader_state_t;

  // True when a counter value sits on the frame's highest index.
  function automatic logic index_at_last(
    input logic [SQUARE_RAM_ADDR_WIDTH-1:0] value,
    input logic [SQUARE_RAM_ADDR_WIDTH-1:0] last_index
  );
    return (value == last_index);
  endfunction

endpackage

// File: rtl/square_raster_counter.sv
// Two-axis raster counter; order=0 steps y first (row-major), order=1 steps x first.
module square_raster_counter
  import square_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = SQUARE_RAM_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] last_index,
  input  logic                  order,
  output logic [ADDR_WIDTH-1:0] x,
  output logic [ADDR_WIDTH-1:0] y,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(1'b0);

  logic [ADDR_WIDTH-1:0] x_r;
  logic [ADDR_WIDTH-1:0] y_r;
  logic [ADDR_WIDTH-1:0] x_next_s;
  logic [ADDR_WIDTH-1:0] y_next_s;
  logic                  x_at_last_s;
  logic                  y_at_last_s;

  // Wrap is an equality compare so the counters never run past last_index.
  always_comb begin
    x_at_last_s = (x_r == last_index);
    y_at_last_s = (y_r == last_index);
    x_next_s    = x_r;
    y_next_s    = y_r;
    if (order) begin
      if (x_at_last_s) begin
        x_next_s = ZERO;
        y_next_s = y_at_last_s ? ZERO : (y_r + ONE);
      end else begin
        x_next_s = x_r + ONE;
      end
    end else begin
      if (y_at_last_s) begin
        y_next_s = ZERO;
        x_next_s = x_at_last_s ? ZERO : (x_r + ONE);
      end else begin
        y_next_s = y_r + ONE;
      end
    end
  end

  // Counter registers: cleared on reset or frame start, stepped per accepted beat.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x_r <= ZERO;
      y_r <= ZERO;
    end else if (clear) begin
      x_r <= ZERO;
      y_r <= ZERO;
    end else if (advance) begin
      x_r <= x_next_s;
      y_r <= y_next_s;
    end else begin
      x_r <= x_r;
      y_r <= y_r;
    end
  end

  assign x    = x_r;
  assign y    = y_r;
  assign last = x_at_last_s && y_at_last_s;

endmodule

// File: rtl/square_ram_raster_loader.sv
// Stream-to-square-RAM raster loader. Optional column-major order via
// SQUARE_RAM_LOADER_TRANSPOSE_EN (adds the transpose input).
module square_ram_raster_loader
  import square_ram_pkg::*;
#(
  parameter int DATA_WIDTH = SQUARE_RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SQUARE_RAM_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] last_index,
`ifdef SQUARE_RAM_LOADER_TRANSPOSE_EN
  input  logic                  transpose,
`endif
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  ram_write_enable,
  output logic [ADDR_WIDTH-1:0] ram_x,
  output logic [ADDR_WIDTH-1:0] ram_y,
  output logic [DATA_WIDTH-1:0] ram_in_data,
  output logic                  busy,
  output logic                  done
);

  loader_state_t         state_r;
  logic [ADDR_WIDTH-1:0] last_index_r;
  logic                  order_s;
  logic                  write_enable_r;
  logic [ADDR_WIDTH-1:0] x_out_r;
  logic [ADDR_WIDTH-1:0] y_out_r;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  busy_r;
  logic                  done_r;

  logic                  ready_s;
  logic                  accept_s;
  logic                  clear_s;
  logic [ADDR_WIDTH-1:0] cnt_x_s;
  logic [ADDR_WIDTH-1:0] cnt_y_s;
  logic                  cnt_last_s;

`ifdef SQUARE_RAM_LOADER_TRANSPOSE_EN
  logic order_r;
  assign order_s = order_r;
`else
  assign order_s = 1'b0;
`endif

  // Handshake decode: abort blocks acceptance in the same cycle.
  always_comb begin
    ready_s  = (state_r == FILL) && !abort;
    accept_s = s_valid && ready_s;
    clear_s  = (state_r == IDLE) && start;
  end

  square_raster_counter #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear_s),
    .advance    (accept_s),
    .last_index (last_index_r),
    .order      (order_s),
    .x          (cnt_x_s),
    .y          (cnt_y_s),
    .last       (cnt_last_s)
  );

  // Frame FSM and registered RAM-side outputs.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      last_index_r   <= '0;
      write_enable_r <= 1'b0;
      x_out_r        <= '0;
      y_out_r        <= '0;
      data_out_r     <= '0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
`ifdef SQUARE_RAM_LOADER_TRANSPOSE_EN
      order_r        <= 1'b0;
`endif
    end else begin
      write_enable_r <= 1'b0;
      done_r         <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r      <= FILL;
            last_index_r <= last_index;
            busy_r       <= 1'b1;
`ifdef SQUARE_RAM_LOADER_TRANSPOSE_EN
            order_r      <= transpose;
`endif
          end
        end
        FILL: begin
          if (abort) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (accept_s) begin
            write_enable_r <= 1'b1;
            x_out_r        <= cnt_x_s;
            y_out_r        <= cnt_y_s;
            data_out_r     <= s_data;
            if (cnt_last_s) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready          = ready_s;
  assign ram_write_enable = write_enable_r;
  assign ram_x            = x_out_r;
  assign ram_y            = y_out_r;
  assign ram_in_data      = data_out_r;
  assign busy             = busy_r;
  assign done             = done_r;

endmodule

// File: tb/tb_square_ram_raster_loader.sv
// Scoreboard bench for square_ram_raster_loader with ADDR_WIDTH=3.
module tb_square_ram_raster_loader;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] last_index;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          ram_write_enable;
  logic [AW-1:0] ram_x;
  logic [AW-1:0] ram_y;
  logic [DW-1:0] ram_in_data;
  logic          busy;
  logic          done;
`ifdef SQUARE_RAM_LOADER_TRANSPOSE_EN
  logic          transpose;
`endif

  always #5 clock = ~clock;

  square_ram_raster_loader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .start            (start),
    .abort            (abort),
    .last_index       (last_index),
`ifdef SQUARE_RAM_LOADER_TRANSPOSE_EN
    .transpose        (transpose),
`endif
    .s_valid          (s_valid),
    .s_data           (s_data),
    .s_ready          (s_ready),
    .ram_write_enable (ram_write_enable),
    .ram_x            (ram_x),
    .ram_y            (ram_y),
    .ram_in_data      (ram_in_data),
    .busy             (busy),
    .done             (done)
  );

  typedef struct packed {
    logic [AW-1:0] x;
    logic [AW-1:0] y;
    logic [DW-1:0] d;
    logic          dn;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  tests_run    = 0;
  int  tests_failed = 0;
  int  writes_seen  = 0;
  int  dones_seen   = 0;
  int  busy_cycles  = 0;
  int  model_li     = 0;
  bit  model_tr     = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected write for beat number idx of the current frame.
  task automatic push_exp(input int idx, input logic [DW-1:0] d);
    wr_t e;
    int n = model_li + 1;
    int a = idx / n;
    int b = idx % n;
    if (model_tr) begin
      e.x = b[AW-1:0];
      e.y = a[AW-1:0];
    end else begin
      e.x = a[AW-1:0];
      e.y = b[AW-1:0];
    end
    e.d  = d;
    e.dn = (idx == n * n - 1);
    exp_q.push_back(e);
  endtask

  // RAM-side monitor.
  always @(negedge clock) begin
    if (busy) busy_cycles++;
    if (done) check_eq("done_with_write", ram_write_enable, 1);
    if (ram_write_enable) begin
      writes_seen++;
      if (done) dones_seen++;
      check_eq("write_expected", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check_eq("ram_x", ram_x, mon_e.x);
        check_eq("ram_y", ram_y, mon_e.y);
        check_eq("ram_in_data", ram_in_data, mon_e.d);
        check_eq("done_flag", done, mon_e.dn);
      end
    end
  end

  task automatic clear_counts();
    writes_seen = 0;
    dones_seen  = 0;
    busy_cycles = 0;
  endtask

  task automatic start_frame(input int li, input bit tr);
    start      = 1'b1;
    last_index = li[AW-1:0];
`ifdef SQUARE_RAM_LOADER_TRANSPOSE_EN
    transpose  = tr;
`endif
    model_li   = li;
    model_tr   = tr;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Drive beats until nbeats accepted; abort_at >= 0 raises abort once that many beats are in.
  task automatic feed(input int nbeats, input logic [DW-1:0] base, input bit gaps, input int abort_at);
    int sent = 0;
    int cyc  = 0;
    bit stop = 1'b0;
    while (!stop && sent < nbeats && cyc < 200) begin
      s_valid = gaps ? (cyc % 3 == 0) : 1'b1;
      s_data  = base + sent[DW-1:0];
      abort   = (abort_at >= 0) && (sent == abort_at);
      @(negedge clock);
      check_eq("s_ready", s_ready, !abort);
      if (abort) begin
        stop = 1'b1;
      end else if (s_valid && s_ready) begin
        push_exp(sent, s_data);
        sent++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    s_valid = 1'b0;
    abort   = 1'b0;
    check_eq("feed_in_budget", (cyc < 200), 1);
  endtask

  task automatic expect_counts(input int w, input int d);
    repeat (2) @(negedge clock);
    check_eq("write_count", writes_seen, w);
    check_eq("done_count", dones_seen, d);
    check_eq("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    last_index = '0;
    s_valid    = 1'b0;
    s_data     = '0;
`ifdef SQUARE_RAM_LOADER_TRANSPOSE_EN
    transpose  = 1'b0;
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("reset_outputs",
             {ram_write_enable, ram_x, ram_y, ram_in_data, busy, done, s_ready}, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Basic 3x3 frame.
    clear_counts();
    start_frame(2, 1'b0);
    feed(9, 8'h10, 1'b0, -1);
    @(negedge clock);
    check_eq("done_cycle_busy", busy, 1);
    check_eq("done_cycle_ready", s_ready, 0);
    @(negedge clock);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_ready", s_ready, 0);
    expect_counts(9, 1);

    // Same frame with stream gaps.
    clear_counts();
    start_frame(2, 1'b0);
    feed(9, 8'h10, 1'b1, -1);
    expect_counts(9, 1);

    // Single pixel.
    clear_counts();
    start_frame(0, 1'b0);
    feed(1, 8'hAB, 1'b0, -1);
    expect_counts(1, 1);
    check_eq("single_busy_cycles", busy_cycles, 2);

    // Abort after 5 beats, then restart.
    clear_counts();
    start_frame(3, 1'b0);
    feed(16, 8'h20, 1'b0, 5);
    @(negedge clock);
    check_eq("abort_idle_busy", busy, 0);
    check_eq("abort_idle_ready", s_ready, 0);
    expect_counts(5, 0);
    clear_counts();
    start_frame(3, 1'b0);
    feed(16, 8'h40, 1'b0, -1);
    expect_counts(16, 1);

    // start held during the frame must not relatch last_index.
    clear_counts();
    start_frame(2, 1'b0);
    start      = 1'b1;
    last_index = 3'd0;
    feed(9, 8'h50, 1'b0, -1);
    start = 1'b0;
    expect_counts(9, 1);

    // Reset mid-frame, then a fresh frame.
    clear_counts();
    start_frame(3, 1'b0);
    feed(4, 8'h60, 1'b0, -1);
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_eq("midreset_outputs",
             {ram_write_enable, ram_x, ram_y, ram_in_data, busy, done, s_ready}, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    expect_counts(4, 0);
    clear_counts();
    start_frame(2, 1'b0);
    feed(9, 8'h70, 1'b0, -1);
    expect_counts(9, 1);

`ifdef SQUARE_RAM_LOADER_TRANSPOSE_EN
    // Column-major 2x2 frame.
    clear_counts();
    start_frame(1, 1'b1);
    feed(4, 8'h01, 1'b0, -1);
    expect_counts(4, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
